rr_mux_4_1_arbiter: RTL

Round-robin arbiter and output register that shares one 4:1 selection datapath between four valid/ready requesters. Each cycle it picks at most one requester, drives the 4:1 select from that choice, and captures the selected word into a single-entry output register with a valid/ready handshake downstream. It sits between four independent producers and one shared consumer. It replaces a fixed, externally driven mux select with a fair, self-sequenced one.

---
 rtl/rr_mux_4_1_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/rr_mux_4_1_arbiter.sv
// Round-robin arbiter over four valid/ready requesters that feeds one shared
// 4:1 select and a single-entry output register with a valid/ready handshake.

module rr_mux_4_1_lane #(
    parameter logic [1:0] IDX = 2'd0
) (
    input  logic       rst_n,
    input  logic       load,
    input  logic       valid,
    input  logic [1:0] g,
    output logic       ready
);
    assign ready = rst_n & load & valid & (g == IDX);
endmodule

module rr_mux_4_1_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);
    logic [3:0][W-1:0] d_arr;
    logic [1:0]        last;
    logic [1:0]        g;
    logic [1:0]        idx;
    logic              any;
    logic              load;

    assign d_arr = {d3, d2, d1, d0};
    assign load  = !out_valid | out_ready;

    // Search last+1 .. last+4 (mod 4); the first active requester wins.
    always_comb begin
        g   = last;
        any = 1'b0;
        idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!any && req_valid[idx]) begin
                g   = idx;
                any = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        rr_mux_4_1_lane #(.IDX(2'(i))) u_lane (
            .rst_n (rst_n),
            .load  (load),
            .valid (req_valid[i]),
            .g     (g),
            .ready (req_ready[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            last      <= 2'd3;
        end else if (load) begin
            if (any) begin
                out_data  <= d_arr[g];
                out_sel   <= g;
                out_valid <= 1'b1;
                last      <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
